// File: rtl/bf_program_loader.sv
// bf_program_loader: encodes a Brainfuck byte stream into 3-bit opcodes, writes them to
// program memory from address 0, checks bracket balance/capacity and NOP-fills the remainder.
module bf_program_loader #(
  parameter int INSTR_WIDTH       = 3,
  parameter int PRGMEM_ADDR_WIDTH = 8,
  parameter int STACK_ADDR_WIDTH  = 4
) (
  input  logic                         i_clock,
  input  logic                         i_reset_n,
  input  logic                         i_start,
  input  logic                         i_char_valid,
  input  logic [7:0]                   i_char,
  input  logic                         i_char_last,
  output logic                         o_char_ready,
  output logic                         o_prgmem_in,
  output logic [PRGMEM_ADDR_WIDTH-1:0] o_prgmem_addr,
  output logic [INSTR_WIDTH-1:0]       o_prgmem_data,
  output logic [PRGMEM_ADDR_WIDTH:0]   o_length,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_core_run,
  output logic                         o_error,
  output logic [1:0]                   o_error_code
);

  localparam int AW = PRGMEM_ADDR_WIDTH;
  localparam int LW = PRGMEM_ADDR_WIDTH + 1;
  localparam int DW = STACK_ADDR_WIDTH;
  localparam int IW = INSTR_WIDTH;

  localparam logic [LW-1:0] MEM_SIZE  = {1'b1, {AW{1'b0}}};
  localparam logic [DW-1:0] MAX_DEPTH = {DW{1'b1}};
  localparam logic [DW-1:0] ZERO_DEPTH = {DW{1'b0}};

  localparam logic [IW-1:0] OP_NOP   = 3'b000;
  localparam logic [IW-1:0] OP_INC   = 3'b010;
  localparam logic [IW-1:0] OP_DEC   = 3'b011;
  localparam logic [IW-1:0] OP_RIGHT = 3'b100;
  localparam logic [IW-1:0] OP_LEFT  = 3'b101;
  localparam logic [IW-1:0] OP_OPEN  = 3'b110;
  localparam logic [IW-1:0] OP_CLOSE = 3'b111;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_CLOSE    = 2'b01;
  localparam logic [1:0] ERR_OPEN     = 2'b10;
  localparam logic [1:0] ERR_CAPACITY = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  // MSB flags a command character; low bits carry its opcode.
  function automatic logic [IW:0] encode_char(input logic [7:0] c);
    case (c)
      8'h2B:   return {1'b1, OP_INC};
      8'h2D:   return {1'b1, OP_DEC};
      8'h3E:   return {1'b1, OP_RIGHT};
      8'h3C:   return {1'b1, OP_LEFT};
      8'h5B:   return {1'b1, OP_OPEN};
      8'h5D:   return {1'b1, OP_CLOSE};
      default: return {1'b0, OP_NOP};
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [LW-1:0] length_q, length_d;
  logic [LW-1:0] clr_q, clr_d;
  logic [DW-1:0] depth_q, depth_d;
  logic [1:0]    err_q, err_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [IW-1:0] wr_data_q, wr_data_d;

  logic [IW:0]   enc_s;
  logic          is_cmd_s;
  logic [IW-1:0] op_s;
  logic [LW-1:0] len_upd_s;
  logic [DW-1:0] depth_upd_s;

  assign enc_s     = encode_char(i_char);
  assign is_cmd_s  = enc_s[IW];
  assign op_s      = enc_s[IW-1:0];
  assign len_upd_s = is_cmd_s ? (length_q + LW'(1)) : length_q;

  // Loop depth after the current byte, assuming it is accepted without error.
  always_comb begin
    depth_upd_s = depth_q;
    if (is_cmd_s && (op_s == OP_OPEN)) begin
      depth_upd_s = depth_q + DW'(1);
    end else if (is_cmd_s && (op_s == OP_CLOSE)) begin
      depth_upd_s = depth_q - DW'(1);
    end else begin
      depth_upd_s = depth_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    length_d  = length_q;
    clr_d     = clr_q;
    depth_d   = depth_q;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_start) begin
          state_d  = ST_LOAD;
          length_d = {LW{1'b0}};
          depth_d  = ZERO_DEPTH;
          err_d    = ERR_NONE;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (!i_char_valid) begin
          state_d = ST_LOAD;
        end else if (is_cmd_s && (length_q == MEM_SIZE)) begin
          state_d = ST_ERROR;
          err_d   = ERR_CAPACITY;
        end else if (is_cmd_s && (op_s == OP_CLOSE) && (depth_q == ZERO_DEPTH)) begin
          state_d = ST_ERROR;
          err_d   = ERR_CLOSE;
        end else if (is_cmd_s && (op_s == OP_OPEN) && (depth_q == MAX_DEPTH)) begin
          state_d = ST_ERROR;
          err_d   = ERR_CAPACITY;
        end else begin
          if (is_cmd_s) begin
            wr_en_d   = 1'b1;
            wr_addr_d = length_q[AW-1:0];
            wr_data_d = op_s;
          end else begin
            wr_en_d = 1'b0;
          end
          length_d = len_upd_s;
          depth_d  = depth_upd_s;
          // The final byte is committed first, then the whole program is judged.
          if (!i_char_last) begin
            state_d = ST_LOAD;
          end else if (depth_upd_s != ZERO_DEPTH) begin
            state_d = ST_ERROR;
            err_d   = ERR_OPEN;
          end else if (len_upd_s == MEM_SIZE) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_CLEAR;
            clr_d   = len_upd_s;
          end
        end
      end
      ST_CLEAR: begin
        if (clr_q == MEM_SIZE) begin
          state_d = ST_DONE;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = clr_q[AW-1:0];
          wr_data_d = OP_NOP;
          clr_d     = clr_q + LW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and write-port registers with synchronous active-low reset.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q   <= ST_IDLE;
      length_q  <= {LW{1'b0}};
      clr_q     <= {LW{1'b0}};
      depth_q   <= ZERO_DEPTH;
      err_q     <= ERR_NONE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= {AW{1'b0}};
      wr_data_q <= OP_NOP;
    end else begin
      state_q   <= state_d;
      length_q  <= length_d;
      clr_q     <= clr_d;
      depth_q   <= depth_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign o_char_ready  = (state_q == ST_LOAD);
  assign o_prgmem_in   = wr_en_q;
  assign o_prgmem_addr = wr_addr_q;
  assign o_prgmem_data = wr_data_q;
  assign o_length      = length_q;
  assign o_busy        = (state_q == ST_LOAD) || (state_q == ST_CLEAR);
  assign o_done        = (state_q == ST_DONE);
  assign o_core_run    = (state_q == ST_DONE);
  assign o_error       = (state_q == ST_ERROR);
  assign o_error_code  = err_q;

endmodule
